// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with issue/flush handshake
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0]      LAST    = 5'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [4:0]        cnt_q;
    logic              neg_q;    // quotient/product sign flip
    logic              rneg_q;   // remainder follows dividend sign
    logic [XLEN-1:0]   a_q;      // multiplicand magnitude
    logic [XLEN-1:0]   b_q;      // divisor magnitude
    logic [2*XLEN-1:0] acc_q;    // {partial product high, remaining multiplier bits}
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quot_q;   // dividend shifts out as quotient shifts in

    // Issue-side decode: operand signedness, magnitudes and the one-cycle special cases
    logic            sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept, finish;

    always_comb begin
        sgn_a       = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        sgn_b       = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        neg_a       = sgn_a && rs1_i[XLEN-1];
        neg_b       = sgn_b && rs2_i[XLEN-1];
        abs_a       = neg_a ? -rs1_i : rs1_i;
        abs_b       = neg_b ? -rs2_i : rs2_i;
        div_zero    = op_i[2] && (rs2_i == '0);
        div_ovf     = op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ONES);
        special     = div_zero || div_ovf;
        if (op_i[1])
            special_res = div_zero ? rs1_i : '0;
        else
            special_res = div_zero ? ONES : MIN_NEG;
        accept      = (state_q == IDLE) && start_i && !kill_i;
        finish      = (state_q == CALC) && (cnt_q == LAST) && !kill_i;
    end

    // One shift-add step and one restoring-division step, plus the sign-corrected final value
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN+1:0]   shifted, diff;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quot_next, quot_f, rem_f, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_next = {mul_sum, acc_q[XLEN-1:1]};
        shifted  = {rem_q, quot_q[XLEN-1]};
        diff     = shifted - {2'b00, b_q};
        if (!diff[XLEN+1]) begin
            rem_next  = diff[XLEN:0];
            quot_next = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next  = shifted[XLEN:0];
            quot_next = {quot_q[XLEN-2:0], 1'b0};
        end
        prod   = neg_q ? -acc_next : acc_next;
        quot_f = neg_q ? -quot_next : quot_next;
        rem_f  = rneg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
        case (op_q)
            3'd0:          final_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    final_res = quot_f;
            default:       final_res = rem_f;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; a flush overrides everything and lands in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i)
            state_d = IDLE;
    end

    // Datapath: latch operands on issue, iterate in CALC, capture the result on the way into DONE
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (accept) begin
            op_q   <= op_i;
            rd_q   <= rd_i;
            cnt_q  <= '0;
            neg_q  <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            a_q    <= abs_a;
            b_q    <= abs_b;
            acc_q  <= {{XLEN{1'b0}}, abs_b};
            rem_q  <= '0;
            quot_q <= abs_a;
            if (special) begin
                result_o <= special_res;
                rd_o     <= rd_i;
            end
        end else if (state_q == CALC) begin
            acc_q  <= acc_next;
            rem_q  <= rem_next;
            quot_q <= quot_next;
            cnt_q  <= kill_i ? 5'd0 : cnt_q + 5'd1;
            if (finish) begin
                result_o <= final_res;
                rd_o     <= rd_q;
            end
        end
    end

    // Handshake outputs; done is withheld in a flushed cycle
    always_comb begin
        ready_o = (state_q == IDLE);
        busy_o  = (state_q != IDLE);
        done_o  = (state_q == DONE) && !kill_i;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        kill_i = 1'b0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;
    exp_t scb[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .kill_i(kill_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sbx, ua, ub, p;
        logic signed [31:0] sa32, sb32;
        sa = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa32 = a;
        sb32 = b;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sbx; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa32 / sb32;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return sa32 % sb32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op at a negedge, waits for done, compares latency/busy/result/rd/ready
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int lat, input bit poke);
        exp_t e;
        int n, busy_cnt;
        bit got;
        e.res = model(op, a, b);
        e.rd = rd;
        scb.push_back(e);
        op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = 1; busy_cnt = 0; got = 1'b0;
        while (n <= 60) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin got = 1'b1; break; end
            if (poke && n >= 3 && n <= 20) begin
                start_i = n[0];
                op_i = 3'($urandom_range(7, 0));
                rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        e = scb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout observed none required latency %0d", name, lat);
        end else begin
            if (n !== lat) begin
                errors++;
                $display("FAIL %s latency got %0d want %0d", name, n, lat);
            end
            checks++;
            if (busy_cnt !== lat) begin
                errors++;
                $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, lat);
            end
            checks++;
            if (result_o !== e.res) begin
                errors++;
                $display("FAIL %s result got %h want %h", name, result_o, e.res);
            end
            checks++;
            if (rd_o !== e.rd) begin
                errors++;
                $display("FAIL %s rd got %0d want %0d", name, rd_o, e.rd);
            end
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after got ready=%b busy=%b want ready=1 busy=0", name, ready_o, busy_o);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'd0 || rd_o !== 5'd0) begin
            errors++;
            $display("FAIL %s reset_outputs got ready=%b busy=%b done=%b result=%h rd=%0d want 1 0 0 00000000 0",
                     name, ready_o, busy_o, done_o, result_o, rd_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_i = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_mul();
        run_op("mul_7x_fffffffd", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 33, 1'b0);
        checks++;
        if (result_o !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_const result got %h want FFFFFFEB", result_o);
        end
    endtask

    task automatic test_mul_high();
        run_op("mulhu_ones", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 33, 1'b0);
        checks++;
        if (result_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_const got %h want FFFFFFFE", result_o); end
        run_op("mulh_ones", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 33, 1'b0);
        checks++;
        if (result_o !== 32'h00000000) begin errors++; $display("FAIL mulh_const got %h want 00000000", result_o); end
        run_op("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 33, 1'b0);
        checks++;
        if (result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_const got %h want FFFFFFFF", result_o); end
        run_op("mulh_mixed", 3'd1, 32'h80000000, 32'h7FFFFFFF, 5'd4, 33, 1'b0);
        run_op("mulhsu_mixed", 3'd2, 32'h9ABCDEF0, 32'h12345678, 5'd6, 33, 1'b0);
    endtask

    task automatic test_div();
        run_op("div_neg7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 33, 1'b0);
        checks++;
        if (result_o !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_const got %h want FFFFFFFD", result_o); end
        run_op("rem_neg7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, 33, 1'b0);
        checks++;
        if (result_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_const got %h want FFFFFFFF", result_o); end
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd9, 33, 1'b0);
        checks++;
        if (result_o !== 32'd14) begin errors++; $display("FAIL divu_const got %h want 0000000E", result_o); end
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 33, 1'b0);
        checks++;
        if (result_o !== 32'd2) begin errors++; $display("FAIL remu_const got %h want 00000002", result_o); end
        run_op("rem_100_neg7", 3'd6, 32'd100, 32'hFFFFFFF9, 5'd11, 33, 1'b0);
        run_op("divu_big", 3'd5, 32'hFFFFFFFF, 32'h00010001, 5'd12, 33, 1'b0);
    endtask

    task automatic test_special();
        run_op("divu_by_zero", 3'd5, 32'd5, 32'd0, 5'd13, 1, 1'b0);
        run_op("rem_by_zero", 3'd6, 32'd5, 32'd0, 5'd14, 1, 1'b0);
        run_op("div_overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 1, 1'b0);
        run_op("rem_overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1, 1'b0);
        run_op("div_by_zero", 3'd4, 32'h12345678, 32'd0, 5'd17, 1, 1'b0);
    endtask

    task automatic test_kill();
        int done_seen;
        done_seen = 0;
        op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd20; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        kill_i = 1'b1;
        if (done_o) done_seen++;
        @(negedge clk);
        kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL kill_ready got %b want 1", ready_o); end
        for (int i = 0; i < 30; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL kill_no_done got %0d pulses want 0", done_seen); end
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd4, 5'd21, 33, 1'b0);
        checks++;
        if (result_o !== 32'd12) begin errors++; $display("FAIL mul_after_kill_const got %h want 0000000C", result_o); end
    endtask

    task automatic test_kill_with_start();
        int done_seen;
        done_seen = 0;
        op_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0; rd_i = 5'd22;
        start_i = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_start_idle got ready=%b busy=%b want ready=1 busy=0", ready_o, busy_o);
        end
        for (int i = 0; i < 40; i++) begin
            if (done_o || busy_o) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL kill_start_activity got %0d cycles want 0", done_seen); end
        checks++;
        if (result_o !== 32'd12 || rd_o !== 5'd21) begin
            errors++;
            $display("FAIL kill_keeps_result got %h rd %0d want 0000000C rd 21", result_o, rd_o);
        end
    endtask

    task automatic test_start_ignored();
        run_op("divu_poked", 3'd5, 32'd100, 32'd7, 5'd23, 33, 1'b1);
        checks++;
        if (result_o !== 32'd14) begin errors++; $display("FAIL poked_const got %h want 0000000E", result_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'(i * 2 + 1);
            a = $urandom;
            b = $urandom | 32'h1;
            run_op("back_to_back", op, a, b, 5'(24 + i), 33, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        op_i = 3'd0; rs1_i = 32'd123; rs2_i = 32'd456; rd_i = 5'd30; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        reset_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        reset_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d pulses want 0", done_seen); end
        check_reset_outputs("reset_mid_after");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_kill();
        test_kill_with_start();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
